// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between pc_sequencer and its neighbours.
//   imem_req   : fetch request to instruction memory
//   imem_addr  : fetch address (mirrors pc)
//   imem_ack   : instruction returned; only meaningful while imem_req=1
//   exec_valid : execute slot active; datapath evaluates the instruction
//   stall      : datapath not finished; holds the execute slot
// master = sequencer side, slave = memory/datapath side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        exec_valid;
  logic        stall;

  modport master (
    output imem_req,
    output imem_addr,
    output exec_valid,
    input  imem_ack,
    input  stall
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  exec_valid,
    output imem_ack,
    output stall
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer for the RV32I core.
// Owns the PC, runs the fetch/execute handshake, selects the next PC
// (jalr > jal > taken branch > sequential), traps on misaligned control-flow
// targets and counts retired instructions.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : fetch/execute handshake (pc_sequencer_if.master)
//   br_en, br_taken, jal, jalr, imm, rs1 : control/operands, sampled in EXEC with stall=0
//   pc, pc_plus4: current PC and its link value
//   redirect    : one-cycle pulse after a non-sequential PC update
//   trap, trap_addr : sticky misaligned-target trap and offending address
//   instret     : retired-instruction count
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  // Counter start value after reset; nonzero only to observe the wrap quickly.
  parameter logic [31:0] RESET_INSTRET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        bus,
  input  logic                  br_en,
  input  logic                  br_taken,
  input  logic                  jal,
  input  logic                  jalr,
  input  logic [31:0]           imm,
  input  logic [31:0]           rs1,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  redirect,
  output logic                  trap,
  output logic [31:0]           trap_addr,
  output logic [31:0]           instret
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [31:0] trap_addr_q;
  logic        redirect_q;

  logic [31:0] target;
  logic        nonseq;
  logic        misaligned;
  logic        exec_done;
  logic        retire;
  logic        take_trap;

  assign pc_plus4 = pc_q + 32'd4;

  // Target select; carry-out is dropped by the 32-bit adds.
  always_comb begin
    target = pc_plus4;
    nonseq = 1'b0;
    if (jalr) begin
      target = (rs1 + imm) & 32'hFFFF_FFFE;
      nonseq = 1'b1;
    end else if (jal || (br_en && br_taken)) begin
      target = pc_q + imm;
      nonseq = 1'b1;
    end
  end

  // Sequential targets stay aligned because pc is always aligned.
  assign misaligned = nonseq && (target[1:0] != 2'b00);
  assign exec_done  = (state_q == StExec) && !bus.stall;
  assign retire     = exec_done && !misaligned;
  assign take_trap  = exec_done && misaligned;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (bus.imem_ack) state_d = StExec;
      StExec: begin
        if (retire)         state_d = StFetch;
        else if (take_trap) state_d = StTrap;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.exec_valid = 1'b0;
    trap           = 1'b0;
    unique case (state_q)
      StFetch: bus.imem_req   = 1'b1;
      StExec:  bus.exec_valid = 1'b1;
      StTrap:  trap           = 1'b1;
      default: ;
    endcase
  end

  // PC, counter, trap address and redirect pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      instret_q   <= RESET_INSTRET;
      trap_addr_q <= 32'h0000_0000;
      redirect_q  <= 1'b0;
    end else begin
      redirect_q <= retire && nonseq;
      if (retire) begin
        pc_q      <= target;
        instret_q <= instret_q + 32'd1;
      end
      if (take_trap) begin
        trap_addr_q <= target;
      end
    end
  end

  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign instret       = instret_q;
  assign trap_addr     = trap_addr_q;
  assign redirect      = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        br_en, br_taken, jal, jalr;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc_plus4, trap_addr, instret;
  logic        redirect, trap;

  // Second instance: free-running sequential core with counter preset near wrap.
  logic [31:0] pc2, pc_plus4_2, trap_addr2, instret2;
  logic        redirect2, trap2;

  pc_sequencer_if bus_if ();
  pc_sequencer_if bus2_if ();

  pc_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .RESET_INSTRET (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .br_en     (br_en),
    .br_taken  (br_taken),
    .jal       (jal),
    .jalr      (jalr),
    .imm       (imm),
    .rs1       (rs1),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .trap      (trap),
    .trap_addr (trap_addr),
    .instret   (instret)
  );

  pc_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .RESET_INSTRET (32'hFFFF_FFFF)
  ) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2_if),
    .br_en     (1'b0),
    .br_taken  (1'b0),
    .jal       (1'b0),
    .jalr      (1'b0),
    .imm       (32'h0),
    .rs1       (32'h0),
    .pc        (pc2),
    .pc_plus4  (pc_plus4_2),
    .redirect  (redirect2),
    .trap      (trap2),
    .trap_addr (trap_addr2),
    .instret   (instret2)
  );

  assign bus2_if.imem_ack = 1'b1;
  assign bus2_if.stall    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        br_en;
    logic        br_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] cur_pc;
    logic [31:0] cur_instret;
    logic [31:0] exp_pc;
    logic        exp_redirect;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[14];

  task automatic clear_ctrl();
    br_en = 1'b0; br_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'h0; rs1 = 32'h0;
  endtask

  // Called at a negedge; waits for FETCH, acks, runs EXEC, checks the result.
  task automatic do_instr(input int idx, input vec_t v);
    int waited;
    waited = 0;
    while (bus_if.imem_req !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (bus_if.imem_req !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL v%0d fetch_wait: imem_req never rose within 10 cycles", idx);
      return;
    end
    check($sformatf("v%0d imem_addr", idx), bus_if.imem_addr, v.cur_pc);
    bus_if.imem_ack = 1'b1;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    check($sformatf("v%0d exec_valid", idx), {31'b0, bus_if.exec_valid}, 32'd1);
    check($sformatf("v%0d exec_pc", idx), pc, v.cur_pc);
    check($sformatf("v%0d exec_instret", idx), instret, v.cur_instret);
    br_en = v.br_en; br_taken = v.br_taken; jal = v.jal; jalr = v.jalr;
    imm = v.imm; rs1 = v.rs1;
    @(negedge clk);
    clear_ctrl();
    check($sformatf("v%0d next_pc", idx), pc, v.exp_pc);
    check($sformatf("v%0d redirect", idx), {31'b0, redirect}, {31'b0, v.exp_redirect});
    check($sformatf("v%0d trap", idx), {31'b0, trap}, {31'b0, v.exp_trap});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " imem_addr"}, bus_if.imem_addr, 32'h0);
    check({tag, " imem_req"}, {31'b0, bus_if.imem_req}, 32'd0);
    check({tag, " exec_valid"}, {31'b0, bus_if.exec_valid}, 32'd0);
    check({tag, " redirect"}, {31'b0, redirect}, 32'd0);
    check({tag, " trap"}, {31'b0, trap}, 32'd0);
    check({tag, " trap_addr"}, trap_addr, 32'h0);
    check({tag, " instret"}, instret, 32'h0);
  endtask

  initial begin
    int req_cnt;
    int exec_cnt;

    //             br_en br_tk jal jalr imm            rs1            cur_pc         cur_ir  exp_pc         rd   tr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'd0,  32'h4,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         32'd1,  32'h8,         1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h8,         32'd2,  32'hC,         1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h100,       32'hC,         32'd3,  32'h100,       1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h100,       32'd4,  32'hF0,        1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h100,       32'hF0,        32'd5,  32'h100,       1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h100,       32'd6,  32'h104,       1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h104,       32'd7,  32'h108,       1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4,         32'h2001,      32'h108,       32'd8,  32'h2004,      1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4,         32'h0,         32'h2004,      32'd9,  32'h2008,      1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h2008,      32'd10, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'd11, 32'h0,         1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h10,        32'h0,         32'd12, 32'h10,        1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h6,         32'h0,         32'h10,        32'd13, 32'h10,        1'b0, 1'b1};

    rst = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.stall    = 1'b0;
    clear_ctrl();

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset pc_plus4", pc_plus4, 32'h4);

    // Release; wrap instance: IDLE -> FETCH -> EXEC -> retire (count wraps to 0).
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wrap exec_valid", {31'b0, bus2_if.exec_valid}, 32'd1);
    check("wrap instret_pre", instret2, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap instret_post", instret2, 32'h0);
    check("wrap pc2", pc2, 32'h4);

    for (int i = 0; i < 14; i++) begin
      do_instr(i, vecs[i]);
    end

    // Trap is sticky; nothing fetches or executes until reset.
    check("trap trap_addr", trap_addr, 32'h16);
    for (int i = 0; i < 5; i++) begin
      bus_if.imem_ack = 1'b1;
      @(negedge clk);
      check($sformatf("trap c%0d imem_req", i), {31'b0, bus_if.imem_req}, 32'd0);
      check($sformatf("trap c%0d exec_valid", i), {31'b0, bus_if.exec_valid}, 32'd0);
      check($sformatf("trap c%0d trap", i), {31'b0, trap}, 32'd1);
    end
    bus_if.imem_ack = 1'b0;
    check("trap pc", pc, 32'h10);
    check("trap instret", instret, 32'd13);

    // Handshake and stall: ack held off 5 cycles, stall for 3 EXEC cycles.
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset2");
    rst = 1'b1;
    @(negedge clk);
    req_cnt  = 0;
    exec_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.imem_req === 1'b1) req_cnt++;
      bus_if.imem_ack = (i == 5);
      @(negedge clk);
    end
    bus_if.imem_ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (bus_if.exec_valid === 1'b1) exec_cnt++;
      check($sformatf("stall c%0d pc", j), pc, 32'h0);
      jal          = 1'b1;
      bus_if.stall = (j < 3);
      imm          = (j < 3) ? (32'h44 + 32'(j) * 32'd4) : 32'h20;
      @(negedge clk);
    end
    clear_ctrl();
    bus_if.stall = 1'b0;
    check("hs req_cycles", 32'(req_cnt), 32'd6);
    check("hs exec_cycles", 32'(exec_cnt), 32'd4);
    check("hs next_pc", pc, 32'h20);
    check("hs redirect", {31'b0, redirect}, 32'd1);
    check("hs instret", instret, 32'd1);
    check("hs refetch req", {31'b0, bus_if.imem_req}, 32'd1);
    check("hs imem_addr", bus_if.imem_addr, 32'h20);

    // Async reset mid-EXEC.
    bus_if.imem_ack = 1'b1;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    check("mid exec_valid", {31'b0, bus_if.exec_valid}, 32'd1);
    check("mid redirect_cleared", {31'b0, redirect}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("restart imem_req", {31'b0, bus_if.imem_req}, 32'd1);
    check("restart pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the RV32I core. It owns the PC register and runs a fetch/execute handshake with instruction memory. Each cycle it presents the fetched instruction to the datapath for one execute slot. It then selects the next PC from the branch comparator result, JAL or JALR, and traps on misaligned control-flow targets. It also maintains a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting 0 forces reset state immediately.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory has returned the instruction; sampled only while imem_req=1.
- exec_valid  output  1  high during the execute slot; datapath evaluates the instruction.
- stall  input  1  datapath not finished; holds the execute slot.
- br_en  input  1  instruction is a conditional branch.
- br_taken  input  1  branch comparator result; ignored unless br_en=1.
- jal  input  1  instruction is JAL.
- jalr  input  1  instruction is JALR.
- imm  input  32  sign-extended immediate.
- rs1  input  32  rs1 operand, used for the JALR target.
- pc  output  32  current PC.
- pc_plus4  output  32  pc+4, combinational; used as the link value.
- redirect  output  1  one-cycle pulse: the PC update just taken was non-sequential.
- trap  output  1  misaligned target detected; sticky until reset.
- trap_addr  output  32  offending target address.
- instret  output  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
  - IDLE: entered from reset. Moves to FETCH on the next edge.
  - FETCH: imem_req=1. Stays in FETCH while imem_ack=0. Moves to EXEC on the edge where imem_ack=1.
  - EXEC: exec_valid=1. If stall=1, remains in EXEC with no state change.
  - EXEC, stall=0, computed target aligned: load pc with next_pc, increment instret, go to FETCH.
  - EXEC, stall=0, computed target misaligned: go to TRAP. pc and instret are unchanged. trap_addr is loaded with the target.
  - TRAP: trap=1. imem_req=0 and exec_valid=0. Only reset exits this state.
- next_pc priority is jalr > jal > (br_en & br_taken) > sequential. Multiple asserted selects resolve by this priority.
  - jalr: (rs1 + imm) & 32'hFFFF_FFFE.
  - jal, or taken branch: pc + imm.
  - otherwise: pc + 4.
- Arithmetic is 32-bit modulo 2^32, and target computation ignores carry-out. pc = 32'hFFFF_FFFC with a sequential step yields 32'h0000_0000.
- Misaligned means target[1:0] != 2'b00, checked after the JALR bit-0 clear. Sequential targets are never checked.
- redirect is registered. It is high for the single cycle after a successful EXEC exit that used a jalr, jal or taken-branch target, even if that target equals pc+4. It is never set on a trap.
- instret wraps from 32'hFFFF_FFFF to 0.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, exec_valid=0, redirect=0, trap=0, trap_addr=0, instret=0, state=IDLE.

## Timing
- Minimum instruction period is 2 cycles: FETCH with an immediate ack, then EXEC. IDLE adds 1 cycle, after reset only.
- imem_req and exec_valid are Moore outputs, decoded from state only.
- The FETCH exit on imem_ack and the EXEC exit on stall=0 are both decided in the same cycle they are sampled.
- pc updates on the edge that leaves EXEC. The new imem_addr is visible in the first FETCH cycle.
- All control and operand inputs are sampled only in EXEC cycles where stall=0. They are don't-care elsewhere.
- Reset asserted mid-FETCH or mid-EXEC:
  - All outputs go to reset values asynchronously.
  - No partial PC or counter update occurs.
  - On release, the block restarts in IDLE.

## Test plan
- Sequential run: reset, RESET_PC=0, ack every FETCH cycle, no controls. Required: pc = 0,4,8,12 across successive EXECs, 2 cycles each. instret=3 at the fourth EXEC. redirect never asserts.
- Taken and not-taken branch: pc=0x100, br_en=1, imm=0xFFFF_FFF0.
  - br_taken=1: next pc=0xF0, redirect pulses 1 cycle.
  - br_taken=0: next pc=0x104, no redirect.
  - br_taken=1 with br_en=0: next pc=0x104.
- JALR priority and alignment: jalr=1 and jal=1 together, rs1=0x2001, imm=4. Required: next pc=0x2004 (bit 0 cleared, jal ignored).
- Misaligned trap: jal=1, pc=0x10, imm=6. Required: TRAP entered, trap=1, trap_addr=0x16, pc stays 0x10, instret unchanged, imem_req stays 0 until reset.
- Handshake and stall: hold imem_ack=0 for 5 cycles, then stall=1 for 3 EXEC cycles. Required:
  - imem_req is high for 6 cycles and exec_valid is high for 4 cycles.
  - pc updates only after stall falls.
  - Changing imm while stall=1 does not affect the result.
- Wrap and async reset: pc=0xFFFF_FFFC sequential gives pc=0; preload instret=0xFFFF_FFFF, retire one, gives instret=0. Then drop rst mid-EXEC. Required: all outputs return to reset values before the next clock edge.
